// File: rtl/commit_stage_np.sv
// N-port in-order commit stage: retires scoreboard heads to the register files, LSU and CSR file,
// sequences fences/AMOs through a small FSM and keeps retirement/stall counters.
package commit_stage_np_pkg;

  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC
  } fu_t;

  typedef enum logic [7:0] {
    ADD, SUB, ANDL, ORL, XORL, SLL, SRL,
    LD, SD,
    AMO_LRD, AMO_SCD, AMO_SWAPD, AMO_ADDD,
    CSR_WRITE, CSR_READ, CSR_SET, CSR_CLEAR,
    FENCE, FENCE_I, SFENCE_VMA,
    FLD, FSD, FADD, FMUL, FCVT_F2I, FCVT_I2F, FMV_F2X, FMV_X2F, VFADD
  } fu_op;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    fu_t         fu;
    fu_op        op;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    exception_t  ex;
  } scoreboard_entry_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] result;
  } amo_resp_t;

  function automatic logic is_amo(input fu_op op);
    return op inside {AMO_LRD, AMO_SCD, AMO_SWAPD, AMO_ADDD};
  endfunction

  function automatic logic is_rd_fpr(input fu_op op);
    return op inside {FLD, FADD, FMUL, FCVT_I2F, FMV_X2F, VFADD};
  endfunction

endpackage

module commit_stage_np
  import commit_stage_np_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned CNT_W           = 64
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       halt_i,
  input  logic                                       flush_dcache_i,
  input  logic                                       single_step_i,
  input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0]    commit_instr_i,
  output logic [NR_COMMIT_PORTS-1:0]                 commit_ack_o,
  output logic [NR_COMMIT_PORTS-1:0][4:0]            waddr_o,
  output logic [NR_COMMIT_PORTS-1:0][63:0]           wdata_o,
  output logic [NR_COMMIT_PORTS-1:0]                 we_gpr_o,
  output logic [NR_COMMIT_PORTS-1:0]                 we_fpr_o,
  input  amo_resp_t                                  amo_resp_i,
  output logic                                       amo_valid_commit_o,
  output logic                                       commit_lsu_o,
  input  logic                                       commit_lsu_ready_i,
  input  logic                                       no_st_pending_i,
  output logic [63:0]                                pc_o,
  output fu_op                                       csr_op_o,
  output logic [63:0]                                csr_wdata_o,
  input  logic [63:0]                                csr_rdata_i,
  input  exception_t                                 csr_exception_i,
  output logic                                       csr_write_fflags_o,
  output logic                                       commit_csr_o,
  output logic                                       dirty_fp_state_o,
  output logic                                       fence_o,
  output logic                                       fence_i_o,
  output logic                                       sfence_vma_o,
  output logic                                       flush_commit_o,
  output exception_t                                 exception_o,
  output logic [$clog2(NR_COMMIT_PORTS+1)-1:0]       retire_cnt_o,
  output logic [CNT_W-1:0]                           instret_o,
  output logic [CNT_W-1:0]                           stall_cycles_o
);

  localparam int unsigned C = $clog2(NR_COMMIT_PORTS + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DRAIN    = 2'd1;
  localparam logic [1:0] S_AMO_WAIT = 2'd2;
  localparam logic [1:0] S_FLUSH    = 2'd3;

  localparam logic [1:0] FK_FENCE   = 2'd0;
  localparam logic [1:0] FK_FENCE_I = 2'd1;
  localparam logic [1:0] FK_SFENCE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        fkind_q, fkind_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  scoreboard_entry_t p0;
  logic              dcache_fence0, is_fence0, is_amo0, is_csr0, elig0;
  logic [1:0]        kind0;
  logic              fire_fence;
  logic [1:0]        fire_kind;
  logic              others_ok;
  exception_t        exc;
  logic              unused_bits;

  assign unused_bits = ^{commit_instr_i, csr_exception_i};

  assign p0            = commit_instr_i[0];
  assign pc_o          = p0.pc;
  assign dcache_fence0 = flush_dcache_i && (p0.fu != STORE);
  assign is_fence0     = dcache_fence0 || (p0.op inside {FENCE, FENCE_I, SFENCE_VMA});
  assign is_amo0       = (p0.fu == STORE) && is_amo(p0.op);
  assign is_csr0       = (p0.fu == CSR) && !is_fence0;
  assign elig0         = rst_ni && p0.valid && !p0.ex.valid && !halt_i;

  always_comb begin
    if (dcache_fence0 || p0.op == FENCE_I) kind0 = FK_FENCE_I;
    else if (p0.op == SFENCE_VMA)          kind0 = FK_SFENCE;
    else                                   kind0 = FK_FENCE;
  end

  // Only port 0 can raise an exception; a pending AMO masks the CSR file's.
  always_comb begin
    exc = '0;
    if (rst_ni && p0.valid && !halt_i) begin
      if (p0.ex.valid) begin
        exc = p0.ex;
      end else if (state_q != S_AMO_WAIT && csr_exception_i.valid) begin
        exc.cause = csr_exception_i.cause;
        exc.tval  = p0.ex.tval;
        exc.valid = 1'b1;
      end
    end
  end
  assign exception_o = exc;

  always_comb begin
    commit_ack_o       = '0;
    we_gpr_o           = '0;
    we_fpr_o           = '0;
    commit_lsu_o       = 1'b0;
    amo_valid_commit_o = 1'b0;
    csr_op_o           = ADD;
    csr_wdata_o        = '0;
    csr_write_fflags_o = 1'b0;
    commit_csr_o       = 1'b0;
    dirty_fp_state_o   = 1'b0;
    fence_o            = 1'b0;
    fence_i_o          = 1'b0;
    sfence_vma_o       = 1'b0;
    flush_commit_o     = 1'b0;
    fire_fence         = 1'b0;
    fire_kind          = FK_FENCE;
    state_d            = state_q;
    fkind_d            = fkind_q;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      waddr_o[k] = commit_instr_i[k].rd;
      wdata_o[k] = commit_instr_i[k].result;
    end

    unique case (state_q)
      S_IDLE: begin
        if (elig0) begin
          if (is_fence0) begin
            if (no_st_pending_i) begin
              commit_ack_o[0] = 1'b1;
              fire_fence      = 1'b1;
              fire_kind       = kind0;
              state_d         = S_FLUSH;
            end else begin
              fkind_d = kind0;
              state_d = S_DRAIN;
            end
          end else if (is_amo0) begin
            amo_valid_commit_o = 1'b1;
            if (amo_resp_i.ack) begin
              commit_ack_o[0] = 1'b1;
              wdata_o[0]      = amo_resp_i.result;
              flush_commit_o  = 1'b1;
              state_d         = S_FLUSH;
            end else begin
              state_d = S_AMO_WAIT;
            end
          end else begin
            unique case (p0.fu)
              ALU, LOAD, MULT, CTRL_FLOW, FPU, FPU_VEC: commit_ack_o[0] = 1'b1;
              STORE: begin
                if (commit_lsu_ready_i) begin
                  commit_ack_o[0] = 1'b1;
                  commit_lsu_o    = 1'b1;
                end
              end
              CSR: begin
                if (!csr_exception_i.valid) begin
                  commit_ack_o[0] = 1'b1;
                  commit_csr_o    = 1'b1;
                  wdata_o[0]      = csr_rdata_i;
                  csr_op_o        = p0.op;
                  csr_wdata_o     = p0.result;
                end
              end
              default: ;
            endcase
          end
        end
      end
      S_DRAIN: begin
        if (rst_ni && !halt_i && p0.valid && no_st_pending_i) begin
          commit_ack_o[0] = 1'b1;
          fire_fence      = 1'b1;
          fire_kind       = fkind_q;
          state_d         = S_FLUSH;
        end
      end
      S_AMO_WAIT: begin
        amo_valid_commit_o = rst_ni;
        if (rst_ni && !halt_i && amo_resp_i.ack) begin
          commit_ack_o[0] = 1'b1;
          wdata_o[0]      = amo_resp_i.result;
          flush_commit_o  = 1'b1;
          state_d         = S_FLUSH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fire_fence) begin
      unique case (fire_kind)
        FK_FENCE_I: fence_i_o    = 1'b1;
        FK_SFENCE:  sfence_vma_o = 1'b1;
        default:    fence_o      = 1'b1;
      endcase
    end

    for (int k = 1; k < NR_COMMIT_PORTS; k++) begin
      commit_ack_o[k] = commit_ack_o[k-1] && others_ok
                        && commit_instr_i[k].valid && !commit_instr_i[k].ex.valid
                        && (commit_instr_i[k].fu inside {ALU, LOAD, CTRL_FLOW, MULT, FPU, FPU_VEC});
    end

    // fflags accrue from every retiring FP op; CSR never retires alongside one.
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      we_fpr_o[k] = commit_ack_o[k] && is_rd_fpr(commit_instr_i[k].op);
      we_gpr_o[k] = commit_ack_o[k] && !is_rd_fpr(commit_instr_i[k].op);
      if (commit_ack_o[k] && (commit_instr_i[k].fu inside {FPU, FPU_VEC})) begin
        csr_write_fflags_o = 1'b1;
        csr_wdata_o        = csr_wdata_o | {59'd0, commit_instr_i[k].ex.cause[4:0]};
      end
      if (commit_ack_o[k] && ((commit_instr_i[k].fu inside {FPU, FPU_VEC})
                              || is_rd_fpr(commit_instr_i[k].op)))
        dirty_fp_state_o = 1'b1;
    end
  end

  assign others_ok = (state_q == S_IDLE) && !is_csr0 && !is_fence0 && !is_amo0
                     && !halt_i && !flush_dcache_i && !single_step_i && !exc.valid;

  always_comb begin
    retire_cnt_o = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++)
      retire_cnt_o = retire_cnt_o + C'(commit_ack_o[k]);
  end

  assign instret_d      = instret_q + CNT_W'(retire_cnt_o);
  assign stall_d        = stall_q + CNT_W'(p0.valid && !commit_ack_o[0]);
  assign instret_o      = instret_q;
  assign stall_cycles_o = stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      fkind_q   <= FK_FENCE;
      instret_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      fkind_q   <= fkind_d;
      instret_q <= instret_d;
      stall_q   <= stall_d;
    end
  end

endmodule
